scan_sel_gen: RTL and testbench

//  Sequential slot scanner that drives the select (I[2:0]) and enable (En[2:0]) inputs of the 3-8 decoder.
//  It steps through slots 0..NUM_SLOTS-1 at a programmable rate and inserts a blanking gap before each slot.
//  The decoder therefore produces one active-low strobe at a time, for multiplexed display or keypad scanning.
//  All outputs are registered; this block contains no decoding logic.

---
 rtl/scan_sel_gen.sv | 142 ++++++++++++++
 tb/tb_scan_sel_gen.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sel_gen.sv
// Slot scanner driving the select/enable inputs of a 3-8 decoder with a blanking gap per slot.
// Optional slot skipping is compiled in with the SCAN_SKIP_EN macro (adds the skip_mask port).
module scan_sel_gen #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned BLANK     = 1,
  parameter int unsigned NUM_SLOTS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       hold,
`ifdef SCAN_SKIP_EN
  input  logic [7:0] skip_mask,
`endif
  output logic [2:0] sel,
  output logic [2:0] en,
  output logic       slot_start,
  output logic       frame_done
);

  localparam int unsigned MaxCnt = (DIV > BLANK) ? DIV : BLANK;
  localparam int unsigned CntW = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK == 0) ? 0 : BLANK - 1);
  localparam logic [7:0] SlotMask = 8'((16'h1 << NUM_SLOTS) - 16'h1);
  localparam logic [2:0] SlotWrap = 3'(NUM_SLOTS - 1);
  localparam logic [2:0] EnOn = 3'b100;

  typedef enum logic [1:0] {StIdle, StBlank, StActive} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      avail;
  logic [2:0]      sel_inc;
  logic [2:0]      last_slot;
  logic [3:0]      first_pick, next_pick, cur_pick;

`ifdef SCAN_SKIP_EN
  assign avail = SlotMask & ~skip_mask;
`else
  assign avail = SlotMask;
`endif

  // Returns {found, index}: first available slot at or after start, wrapping within the frame.
  function automatic logic [3:0] pick(input logic [7:0] av, input logic [2:0] start);
    logic [3:0] r;
    int         i;
    r = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      i = int'(start) + k;
      if (i >= int'(NUM_SLOTS)) i = i - int'(NUM_SLOTS);
      if (k < int'(NUM_SLOTS) && av[3'(i)]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [2:0] highest(input logic [7:0] av);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (av[k]) r = 3'(k);
    end
    return r;
  endfunction

  assign sel_inc    = (sel == SlotWrap) ? 3'd0 : sel + 3'd1;
  assign first_pick = pick(avail, 3'd0);
  assign next_pick  = pick(avail, sel_inc);
  assign cur_pick   = pick(avail, sel);
  assign last_slot  = highest(avail);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel        <= 3'd0;
      en         <= 3'b000;
      slot_start <= 1'b0;
      frame_done <= 1'b0;
    end else if (!run) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel        <= 3'd0;
      en         <= 3'b000;
      slot_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          sel   <= first_pick[2:0];
          if (BLANK == 0 && first_pick[3]) begin
            state_q    <= StActive;
            en         <= EnOn;
            slot_start <= 1'b1;
            frame_done <= (DivLast == '0) && (first_pick[2:0] == last_slot);
          end else begin
            state_q <= StBlank;
          end
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            // Re-pick here so a slot masked while blanking is skipped; stall if nothing is left.
            if (cur_pick[3]) begin
              state_q    <= StActive;
              sel        <= cur_pick[2:0];
              en         <= EnOn;
              slot_start <= 1'b1;
              frame_done <= (DivLast == '0) && (cur_pick[2:0] == last_slot);
              cnt_q      <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StActive: begin
          slot_start <= 1'b0;
          // While held, frame_done keeps its value so a hold on the last cycle stretches it.
          if (!hold) begin
            if (cnt_q == DivLast) begin
              cnt_q <= '0;
              sel   <= next_pick[2:0];
              if (BLANK == 0 && next_pick[3]) begin
                slot_start <= 1'b1;
                frame_done <= (DivLast == '0) && (next_pick[2:0] == last_slot);
              end else begin
                state_q    <= StBlank;
                en         <= 3'b000;
                frame_done <= 1'b0;
              end
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              frame_done <= ((cnt_q + 1'b1) == DivLast) && (sel == last_slot);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: default instance plus a NUM_SLOTS=3/BLANK=0/DIV=2 instance,
// checked every cycle against a phase-counter model of the slot schedule.
module tb_scan_sel_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_a, hold_a, run_b, hold_b;
  logic [2:0] sel_a, en_a, sel_b, en_b;
  logic       ss_a, fd_a, ss_b, fd_b;
  logic [7:0] av_a;
  logic [7:0] av_b;
  int         vectors = 0;
  int         errors = 0;

  typedef struct {
    bit running;
    int slot;
    int t;
    bit stalled;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

`ifdef SCAN_SKIP_EN
  logic [7:0] skip_mask;
  assign av_a = ~skip_mask;
`else
  assign av_a = 8'hFF;
`endif
  assign av_b = 8'h07;

  scan_sel_gen dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_a),
    .hold       (hold_a),
`ifdef SCAN_SKIP_EN
    .skip_mask  (skip_mask),
`endif
    .sel        (sel_a),
    .en         (en_a),
    .slot_start (ss_a),
    .frame_done (fd_a)
  );

  scan_sel_gen #(.DIV(2), .BLANK(0), .NUM_SLOTS(3)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_b),
    .hold       (hold_b),
`ifdef SCAN_SKIP_EN
    .skip_mask  (8'h00),
`endif
    .sel        (sel_b),
    .en         (en_b),
    .slot_start (ss_b),
    .frame_done (fd_b)
  );

  // Next available slot after 'from', cyclically within n slots.
  function automatic int nxt(input logic [7:0] av, input int n, input int from);
    int i;
    for (int k = 1; k <= n; k++) begin
      i = (from + k) % n;
      if (av[i]) return i;
    end
    return 0;
  endfunction

  function automatic int last_av(input logic [7:0] av, input int n);
    for (int i = n - 1; i >= 0; i--) if (av[i]) return i;
    return 0;
  endfunction

  // Slot period is b+d phases: phases [0,b) blank, [b,b+d) active.
  function automatic mdl_t mstep(input mdl_t m, input bit r, input bit h, input int n,
                                 input int b, input int d, input logic [7:0] av);
    mdl_t o;
    o = m;
    if (!r) begin
      o.running = 0; o.slot = 0; o.t = 0; o.stalled = 0;
    end else if (!m.running) begin
      o.running = 1; o.slot = nxt(av, n, n - 1); o.t = 0; o.stalled = 0;
    end else if (h && m.t >= b) begin
      o.stalled = 1;
    end else begin
      o.stalled = 0;
      o.t = m.t + 1;
      if (o.t == b + d) begin
        o.t = 0;
        o.slot = nxt(av, n, m.slot);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] mout(input mdl_t m, input int n, input int b, input int d,
                                     input logic [7:0] av);
    logic [2:0] s;
    if (!m.running) return 8'h00;
    s = 3'(m.slot);
    return {s, (m.t >= b) ? 3'b100 : 3'b000, (m.t == b) && !m.stalled,
            (m.t == b + d - 1) && (m.slot == last_av(av, n))};
  endfunction

  function automatic mdl_t mreset();
    mdl_t o;
    o.running = 0; o.slot = 0; o.t = 0; o.stalled = 0;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      ma = mreset();
      mb = mreset();
    end else begin
      ma = mstep(ma, run_a, hold_a, 8, 1, 4, av_a);
      mb = mstep(mb, run_b, hold_b, 3, 0, 2, av_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    #3;
    vectors++;
    if ({sel_a, en_a, ss_a, fd_a} !== 8'h00) begin
      errors++;
      $display("FAIL reset_a: got %h expected 00", {sel_a, en_a, ss_a, fd_a});
    end
    vectors++;
    if ({sel_b, en_b, ss_b, fd_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_b: got %h expected 00", {sel_b, en_b, ss_b, fd_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_a = 1'b1;
    repeat (3) tick();
    exp = mout(ma, 8, 1, 4, av_a);
    vectors++;
    if ({sel_a, en_a, ss_a, fd_a} !== exp || en_a !== 3'b100) begin
      errors++;
      $display("FAIL pre_reset_active: got %h expected %h", {sel_a, en_a, ss_a, fd_a}, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({sel_a, en_a, ss_a, fd_a} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %h expected 00", {sel_a, en_a, ss_a, fd_a});
    end
    ma = mreset();
    mb = mreset();
    run_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [7:0] exp;
    int         fd_cyc[$];
    run_a = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      tick();
      exp = mout(ma, 8, 1, 4, av_a);
      vectors++;
      if ({sel_a, en_a, ss_a, fd_a} !== exp) begin
        errors++;
        $display("FAIL frame c%0d: got %h expected %h", c, {sel_a, en_a, ss_a, fd_a}, exp);
      end
      if (c == 1 || c == 2) begin
        vectors++;
        if ({sel_a, en_a} !== ((c == 1) ? 6'b000_000 : 6'b000_100)) begin
          errors++;
          $display("FAIL frame_start c%0d: got sel=%0d en=%b", c, sel_a, en_a);
        end
      end
      if (fd_a === 1'b1) begin
        fd_cyc.push_back(c);
        vectors++;
        if (sel_a !== 3'd7 || en_a !== 3'b100) begin
          errors++;
          $display("FAIL frame_done_pos: got sel=%0d en=%b expected sel=7 en=100", sel_a, en_a);
        end
      end
    end
    vectors++;
    if (fd_cyc.size() < 2 || fd_cyc[1] - fd_cyc[0] != 40) begin
      errors++;
      $display("FAIL frame_period: got %0d pulses, expected 2+ spaced 40", fd_cyc.size());
    end
  endtask

  task automatic test_hold();
    int n3 = 0;
    int guard = 0;
    logic [7:0] exp;
    while (!(sel_a == 3'd3 && ss_a) && guard < 100) begin
      tick();
      guard++;
    end
    vectors++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL hold_wait: got no slot 3 start, expected one within 100 cycles");
      return;
    end
    n3 = 1;
    hold_a = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sel_a == 3'd3 && en_a == 3'b100) n3++;
      exp = mout(ma, 8, 1, 4, av_a);
      vectors++;
      if ({sel_a, en_a, ss_a, fd_a} !== exp) begin
        errors++;
        $display("FAIL hold c%0d: got %h expected %h", c, {sel_a, en_a, ss_a, fd_a}, exp);
      end
    end
    hold_a = 1'b0;
    guard = 0;
    while (sel_a == 3'd3 && guard < 20) begin
      tick();
      guard++;
      if (sel_a == 3'd3 && en_a == 3'b100) n3++;
    end
    vectors++;
    if (n3 != 14 || sel_a !== 3'd4) begin
      errors++;
      $display("FAIL hold_len: got %0d cycles then sel=%0d, expected 14 then sel=4", n3, sel_a);
    end
  endtask

  task automatic test_run_stop();
    int guard = 0;
    while (!(sel_a == 3'd5 && en_a == 3'b100) && guard < 100) begin
      tick();
      guard++;
    end
    run_a = 1'b0;
    tick();
    vectors++;
    if ({sel_a, en_a, ss_a, fd_a} !== 8'h00 || guard >= 100) begin
      errors++;
      $display("FAIL run_stop: got %h expected 00", {sel_a, en_a, ss_a, fd_a});
    end
    tick();
    run_a = 1'b1;
    tick();
    tick();
    vectors++;
    if ({sel_a, en_a, ss_a} !== {3'd0, 3'b100, 1'b1}) begin
      errors++;
      $display("FAIL restart: got sel=%0d en=%b ss=%b expected 0/100/1", sel_a, en_a, ss_a);
    end
  endtask

  task automatic test_short();
    logic [7:0] exp;
    int         last_fd = -1;
    run_a = 1'b0;
    run_b = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      exp = mout(mb, 3, 0, 2, av_b);
      vectors++;
      if ({sel_b, en_b, ss_b, fd_b} !== exp || en_b !== 3'b100
          || sel_b !== 3'(((c - 1) / 2) % 3)) begin
        errors++;
        $display("FAIL short c%0d: got %h expected %h", c, {sel_b, en_b, ss_b, fd_b}, exp);
      end
      if (fd_b === 1'b1) begin
        if (last_fd >= 0) begin
          vectors++;
          if (c - last_fd != 6) begin
            errors++;
            $display("FAIL short_frame: got period %0d expected 6", c - last_fd);
          end
        end
        last_fd = c;
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] ea, eb;
    for (int c = 0; c < 3000; c++) begin
      run_a  = ($urandom_range(0, 29) != 0);
      hold_a = ($urandom_range(0, 3) == 0);
      run_b  = ($urandom_range(0, 29) != 0);
      hold_b = ($urandom_range(0, 3) == 0);
      tick();
      ea = mout(ma, 8, 1, 4, av_a);
      eb = mout(mb, 3, 0, 2, av_b);
      vectors++;
      if ({sel_a, en_a, ss_a, fd_a} !== ea) begin
        errors++;
        $display("FAIL random_a c%0d: got %h expected %h", c, {sel_a, en_a, ss_a, fd_a}, ea);
      end
      vectors++;
      if ({sel_b, en_b, ss_b, fd_b} !== eb) begin
        errors++;
        $display("FAIL random_b c%0d: got %h expected %h", c, {sel_b, en_b, ss_b, fd_b}, eb);
      end
    end
    hold_a = 1'b0;
    hold_b = 1'b0;
  endtask

`ifdef SCAN_SKIP_EN
  task automatic test_skip();
    logic [7:0] exp;
    int         seen[$];
    int         guard = 0;
    run_a = 1'b0;
    run_b = 1'b0;
    tick();
    skip_mask = 8'b1010_0101;
    run_a = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      exp = mout(ma, 8, 1, 4, av_a);
      vectors++;
      if ({sel_a, en_a, ss_a, fd_a} !== exp) begin
        errors++;
        $display("FAIL skip c%0d: got %h expected %h", c, {sel_a, en_a, ss_a, fd_a}, exp);
      end
      if (ss_a === 1'b1) seen.push_back(int'(sel_a));
      if (fd_a === 1'b1) begin
        vectors++;
        if (sel_a !== 3'd6) begin
          errors++;
          $display("FAIL skip_frame_done: got sel=%0d expected 6", sel_a);
        end
      end
    end
    vectors++;
    if (seen.size() < 4 || seen[0] != 1 || seen[1] != 3 || seen[2] != 4 || seen[3] != 6) begin
      errors++;
      $display("FAIL skip_order: got %0d starts, expected order 1,3,4,6", seen.size());
    end
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    skip_mask = 8'hFF;
    for (int c = 0; c < 30; c++) begin
      tick();
      vectors++;
      if (en_a !== 3'b000 || ss_a !== 1'b0 || fd_a !== 1'b0) begin
        errors++;
        $display("FAIL skip_all: got en=%b ss=%b fd=%b expected 000/0/0", en_a, ss_a, fd_a);
      end
    end
    skip_mask = 8'hEF;
    while (ss_a !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    vectors++;
    if (guard >= 20 || sel_a !== 3'd4) begin
      errors++;
      $display("FAIL skip_resume: got sel=%0d after %0d cycles, expected sel=4", sel_a, guard);
    end
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    run_a  = 1'b0;
    hold_a = 1'b0;
    run_b  = 1'b0;
    hold_b = 1'b0;
`ifdef SCAN_SKIP_EN
    skip_mask = 8'h00;
`endif
    ma = mreset();
    mb = mreset();
    test_reset();
    test_frame();
    test_hold();
    test_run_stop();
    test_short();
    test_random();
`ifdef SCAN_SKIP_EN
    test_skip();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
